// File: rtl/uart_rx.sv
// uart_rx: 8N1 UART receiver with 2-flop input synchroniser and mid-bit sampling.
// Optional feature: define UART_RX_PARITY_EN to receive 8E1 frames
// (even-parity bit after the data bits, mismatch reported on parity_err).
module uart_rx #(
    parameter int CLKS_PER_BIT = 434,
    parameter int DATA_BITS    = 8
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 rx,
    output logic [DATA_BITS-1:0] rx_data,
    output logic                 rx_valid,
    output logic                 frame_err,
    output logic                 parity_err,
    output logic                 busy
);

    localparam int            CW   = $clog2(CLKS_PER_BIT);
    localparam logic [CW-1:0] HALF = CW'((CLKS_PER_BIT - 1) / 2);
    localparam logic [CW-1:0] LAST = CW'(CLKS_PER_BIT - 1);
    localparam logic [2:0]    LAST_BIT = 3'(DATA_BITS - 1);

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
        PARITY,
        STOP
    } state_t;

    state_t               state;
    logic                 rx_m;
    logic                 rx_s;
    logic [CW-1:0]        clk_cnt;
    logic [2:0]           bit_idx;
    logic [DATA_BITS-1:0] shift;
`ifdef UART_RX_PARITY_EN
    logic                 par_bit;
`endif

    // Two-flop synchroniser; preset high so reset does not look like a start bit
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rx_m <= 1'b1;
            rx_s <= 1'b1;
        end else begin
            rx_m <= rx;
            rx_s <= rx_m;
        end
    end

    assign busy = (state != IDLE);

`ifndef UART_RX_PARITY_EN
    assign parity_err = 1'b0;
`endif

    // Receive FSM: start-bit qualify, mid-bit data sampling, stop-bit check
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= IDLE;
            clk_cnt   <= '0;
            bit_idx   <= '0;
            shift     <= '0;
            rx_data   <= '0;
            rx_valid  <= 1'b0;
            frame_err <= 1'b0;
`ifdef UART_RX_PARITY_EN
            par_bit    <= 1'b0;
            parity_err <= 1'b0;
`endif
        end else begin
            rx_valid  <= 1'b0;
            frame_err <= 1'b0;
`ifdef UART_RX_PARITY_EN
            parity_err <= 1'b0;
`endif
            case (state)
                IDLE: begin
                    clk_cnt <= '0;
                    if (!rx_s) state <= START;
                end
                START: begin
                    if (clk_cnt == HALF) begin
                        clk_cnt <= '0;
                        bit_idx <= '0;
                        // still low at mid start bit: real frame, otherwise a glitch
                        state   <= rx_s ? IDLE : DATA;
                    end else begin
                        clk_cnt <= clk_cnt + CW'(1);
                    end
                end
                DATA: begin
                    if (clk_cnt == LAST) begin
                        clk_cnt        <= '0;
                        shift[bit_idx] <= rx_s;
                        if (bit_idx == LAST_BIT) begin
`ifdef UART_RX_PARITY_EN
                            state <= PARITY;
`else
                            state <= STOP;
`endif
                        end else begin
                            bit_idx <= bit_idx + 3'd1;
                        end
                    end else begin
                        clk_cnt <= clk_cnt + CW'(1);
                    end
                end
`ifdef UART_RX_PARITY_EN
                PARITY: begin
                    if (clk_cnt == LAST) begin
                        clk_cnt <= '0;
                        par_bit <= rx_s;
                        state   <= STOP;
                    end else begin
                        clk_cnt <= clk_cnt + CW'(1);
                    end
                end
`endif
                STOP: begin
                    // Sampled at mid stop bit; returning to IDLE here leaves half a
                    // bit of margin so back-to-back frames need no idle gap.
                    if (clk_cnt == LAST) begin
                        clk_cnt <= '0;
                        state   <= IDLE;
                        if (!rx_s) begin
                            frame_err <= 1'b1;
`ifdef UART_RX_PARITY_EN
                        end else if (^{shift, par_bit}) begin
                            parity_err <= 1'b1;
`endif
                        end else begin
                            rx_data  <= shift;
                            rx_valid <= 1'b1;
                        end
                    end else begin
                        clk_cnt <= clk_cnt + CW'(1);
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule
